shift_register_burst: RTL

Parametrised universal shift register, successor to the fixed-function `shift_register`. It adds multi-bit shift amounts, arithmetic and rotate modes, and serial in/out. A burst sequencer repeats one captured operation a programmed number of times under a start/busy/done handshake. It sits wherever the design needs a serialiser, barrel-shift stage or pattern generator. The gate-level post-route netlist must remain equivalent to this RTL.

---
 rtl/shift_register_pkg.sv | 31 +++
 rtl/shift_unit.sv | 51 +++++
 rtl/shift_register_burst.sv | 129 ++++++++++++
 3 files changed

// File: rtl/shift_register_pkg.sv
// Shared types and helpers for the shift_register_burst block.
//   mode_e    : operation select encoding (hold, shifts, load, rotates)
//   state_e   : burst sequencer states
//   sout_idx  : index of the old register bit that becomes sout
package shift_register_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_SHL  = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_LOAD = 3'd3,
        MODE_ASR  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_ROL  = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Leftward moves lose bit n-sh last; rightward moves lose bit sh-1 last.
    // The result is meaningless for sh=0; callers gate sout updates on that.
    function automatic int sout_idx(input int n, input mode_e m, input int sh);
        if (m == MODE_SHL || m == MODE_ROL) return n - sh;
        return sh - 1;
    endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational barrel shifter / rotator.
//   q         : current register value
//   mode      : operation (load and hold both pass q through)
//   shamt     : shift / rotate amount
//   sin       : fill bit for logical shifts
//   q_next    : shifted / rotated value
//   sout_next : old bit that leaves the register
//   sout_en   : high when sout should update (move op with nonzero shamt)
module shift_unit
    import shift_register_pkg::*;
#(
    parameter int N   = 8,
    parameter int SHW = $clog2(N)
) (
    input  logic [N-1:0]   q,
    input  mode_e          mode,
    input  logic [SHW-1:0] shamt,
    input  logic           sin,
    output logic [N-1:0]   q_next,
    output logic           sout_next,
    output logic           sout_en
);

    // Double-width words: the fill (or a second copy of q for rotates)
    // sits next to q so one shift yields the result in one half.
    logic [2*N-1:0] shl_w, shr_w, asr_w, rol_w, ror_w;
    logic [SHW-1:0] idx;

    always_comb begin
        shl_w     = {q, {N{sin}}} << shamt;
        shr_w     = {{N{sin}}, q} >> shamt;
        asr_w     = {{N{q[N-1]}}, q} >> shamt;
        rol_w     = {q, q} << shamt;
        ror_w     = {q, q} >> shamt;
        idx       = SHW'(sout_idx(N, mode, int'(shamt)));
        q_next    = q;
        sout_en   = 1'b0;
        sout_next = q[idx];
        case (mode)
            MODE_SHL: q_next = shl_w[2*N-1:N];
            MODE_SHR: q_next = shr_w[N-1:0];
            MODE_ASR: q_next = asr_w[N-1:0];
            MODE_ROR: q_next = ror_w[N-1:0];
            MODE_ROL: q_next = rol_w[2*N-1:N];
            default:  q_next = q;
        endcase
        if (mode inside {MODE_SHL, MODE_SHR, MODE_ASR, MODE_ROR, MODE_ROL})
            sout_en = (shamt != '0);
    end

endmodule

// File: rtl/shift_register_burst.sv
// Universal shift register with a burst sequencer.
//   clk, reset : clock, async active-low reset
//   mode       : operation select (mode_e encoding)
//   shamt      : shift / rotate amount
//   data       : parallel load value
//   sin        : serial fill bit for logical shifts
//   start      : burst request, sampled only in IDLE
//   count      : number of operations in the burst
//   q_reg      : register contents
//   sout       : last bit shifted / rotated out
//   busy, done : burst running / one-cycle completion pulse
module shift_register_burst
    import shift_register_pkg::*;
#(
    parameter int N    = 8,
    parameter int SHW  = $clog2(N),
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      mode,
    input  logic [SHW-1:0]  shamt,
    input  logic [N-1:0]    data,
    input  logic            sin,
    input  logic            start,
    input  logic [CNTW-1:0] count,
    output logic [N-1:0]    q_reg,
    output logic            sout,
    output logic            busy,
    output logic            done
);

    state_e          state;
    mode_e           cap_mode;
    logic [SHW-1:0]  cap_shamt;
    logic [N-1:0]    cap_data;
    logic            cap_sin;
    logic [CNTW-1:0] remaining;

    mode_e           op_mode;
    logic [SHW-1:0]  op_shamt;
    logic [N-1:0]    op_data;
    logic            op_sin;
    logic [N-1:0]    q_next, q_apply;
    logic            sout_next, sout_en;

    // During RUN the captured operation drives the datapath; otherwise live inputs.
    always_comb begin
        op_mode  = mode_e'(mode);
        op_shamt = shamt;
        op_data  = data;
        op_sin   = sin;
        if (state == RUN) begin
            op_mode  = cap_mode;
            op_shamt = cap_shamt;
            op_data  = cap_data;
            op_sin   = cap_sin;
        end
        q_apply = (op_mode == MODE_LOAD) ? op_data : q_next;
    end

    shift_unit #(.N(N), .SHW(SHW)) u_shift (
        .q         (q_reg),
        .mode      (op_mode),
        .shamt     (op_shamt),
        .sin       (op_sin),
        .q_next    (q_next),
        .sout_next (sout_next),
        .sout_en   (sout_en)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            q_reg     <= '0;
            sout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            cap_mode  <= MODE_HOLD;
            cap_shamt <= '0;
            cap_data  <= '0;
            cap_sin   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Capture edge: register holds, operations begin next edge.
                        cap_mode  <= mode_e'(mode);
                        cap_shamt <= shamt;
                        cap_data  <= data;
                        cap_sin   <= sin;
                        remaining <= count;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        q_reg <= q_apply;
                        if (sout_en) sout <= sout_next;
                    end
                end
                RUN: begin
                    q_reg     <= q_apply;
                    if (sout_en) sout <= sout_next;
                    remaining <= remaining - 1'b1;
                    if (remaining == CNTW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
